// File: rtl/seg_scan_decoder.sv
`timescale 1ns/1ps
// Watches a multiplexed active-low 7-segment bus, rebuilds each digit as ASCII
// and emits a full frame whenever the displayed text changes.
module seg_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int SETTLE     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic                    frame_valid,
  output logic [8*NUM_DIGITS-1:0] frame_chars,
  output logic                    frame_err
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [7:0]            CNT_LAST = 8'(SETTLE - 1);
  localparam logic [NUM_DIGITS-1:0] ONE      = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [8*NUM_DIGITS-1:0] slots_q;
  logic [NUM_DIGITS-1:0]   errs_q;
  logic                    done_q;
  logic                    first_q;
  logic                    valid_q;
  logic [8*NUM_DIGITS-1:0] chars_q;
  logic                    err_q;

  logic [NUM_DIGITS-1:0] sel;
  logic                  an_ok;
  logic                  change;
  logic                  capture;
  logic                  complete;
  logic [7:0]            dec_char;
  logic                  dec_bad;

  assign sel      = ~an_n;
  assign an_ok    = (sel != '0) && ((sel & (sel - ONE)) == '0);
  assign change   = (an_n != an_q) || (seg_n != seg_q);
  assign complete = ((mask_q | sel) == '1);

  always_comb begin
    dec_bad  = 1'b0;
    dec_char = 8'h3F;
    case (seg_n)
      7'b0001001: dec_char = 8'h48;
      7'b0001000: dec_char = 8'h41;
      7'b0001100: dec_char = 8'h50;
      7'b0010001: dec_char = 8'h59;
      7'b0000011: dec_char = 8'h42;
      7'b0100001: dec_char = 8'h44;
      7'b0010010: dec_char = 8'h53;
      7'b0000111: dec_char = 8'h54;
      7'b0100011: dec_char = 8'h4F;
      7'b1000110: dec_char = 8'h43;
      7'b0101011: dec_char = 8'h4E;
      7'b1111111: dec_char = 8'h20;
      default:    dec_bad  = 1'b1;
    endcase
  end

  // cnt_q counts edges for which the current bus value has been unchanged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (an_ok) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (!an_ok) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end else if (change) begin
          cnt_d = 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          state_d = S_HOLD;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (change) begin
          state_d = an_ok ? S_SETTLE : S_WAIT;
          cnt_d   = an_ok ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= '1;
      state_q <= S_WAIT;
      cnt_q   <= 8'd0;
      mask_q  <= '0;
      slots_q <= '0;
      errs_q  <= '0;
      done_q  <= 1'b0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      chars_q <= '0;
      err_q   <= 1'b0;
    end else begin
      an_q    <= an_n;
      seg_q   <= seg_n;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            slots_q[8*i +: 8] <= dec_char;
            errs_q[i]         <= dec_bad;
          end
        end
        if (complete) begin
          mask_q <= '0;
          done_q <= 1'b1;
        end else begin
          mask_q <= mask_q | sel;
        end
      end
      // Slots cannot be recaptured on the edge after completion, so they are read directly.
      if (done_q && (first_q || (slots_q != chars_q))) begin
        valid_q <= 1'b1;
        chars_q <= slots_q;
        err_q   <= |errs_q;
        first_q <= 1'b0;
      end
    end
  end

  assign frame_valid = valid_q;
  assign frame_chars = chars_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
`timescale 1ns/1ps
// Bench for seg_scan_decoder: run-length reference model feeding an expected
// frame queue, with a monitor that checks every emitted frame and the hold value.
module tb_seg_scan_decoder;

  localparam int N      = 4;
  localparam int SETTLE = 4;
  localparam int CW     = 8 * N;
  localparam int EW     = 32 + 1 + CW;

  localparam logic [6:0] G_H = 7'b0001001, G_A = 7'b0001000, G_P = 7'b0001100;
  localparam logic [6:0] G_Y = 7'b0010001, G_B = 7'b0000011, G_D = 7'b0100001;
  localparam logic [6:0] G_S = 7'b0010010, G_T = 7'b0000111, G_O = 7'b0100011;
  localparam logic [6:0] G_C = 7'b1000110, G_SP = 7'b1111111, G_BAD = 7'b1111110;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  an_n;
  logic [6:0]    seg_n;
  logic          frame_valid;
  logic [CW-1:0] frame_chars;
  logic          frame_err;

  seg_scan_decoder #(.NUM_DIGITS(N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .frame_valid (frame_valid),
    .frame_chars (frame_chars),
    .frame_err   (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [6:0] pat_tab [12] = '{7'b0001001, 7'b0001000, 7'b0001100, 7'b0010001,
                               7'b0000011, 7'b0100001, 7'b0010010, 7'b0000111,
                               7'b0100011, 7'b1000110, 7'b0101011, 7'b1111111};
  logic [7:0] chr_tab [12] = '{8'h48, 8'h41, 8'h50, 8'h59, 8'h42, 8'h44,
                               8'h53, 8'h54, 8'h4F, 8'h43, 8'h4E, 8'h20};

  int n_checks  = 0;
  int n_fail    = 0;
  int edge_cnt  = 0;
  int pulse_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] mon_chars = '0;
  logic          mon_err   = 1'b0;

  // reference model state
  logic [7:0]    m_slot [N];
  logic          m_err  [N];
  logic          m_mask [N];
  logic          m_first;
  logic [CW-1:0] m_last;
  logic [N-1:0]  m_prev_an;
  logic [6:0]    m_prev_seg;
  int            m_run;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_slot[i] = 8'h00;
      m_err[i]  = 1'b0;
      m_mask[i] = 1'b0;
    end
    m_first    = 1'b1;
    m_last     = '0;
    m_prev_an  = '1;
    m_prev_seg = '1;
    m_run      = 0;
  endtask

  function automatic int low_count(input logic [N-1:0] an);
    int c = 0;
    for (int i = 0; i < N; i++) if (!an[i]) c++;
    return c;
  endfunction

  task automatic model_capture(input int d, input logic [6:0] seg, input int cap_edge);
    logic [7:0]    ch   = 8'h3F;
    logic          bad  = 1'b1;
    logic          full = 1'b1;
    logic          any_err = 1'b0;
    logic [CW-1:0] chars = '0;
    for (int k = 0; k < 12; k++) begin
      if (pat_tab[k] == seg) begin
        ch  = chr_tab[k];
        bad = 1'b0;
      end
    end
    m_slot[d] = ch;
    m_err[d]  = bad;
    m_mask[d] = 1'b1;
    for (int i = 0; i < N; i++) full = full & m_mask[i];
    if (full) begin
      for (int i = 0; i < N; i++) begin
        m_mask[i]       = 1'b0;
        chars[8*i +: 8] = m_slot[i];
        any_err         = any_err | m_err[i];
      end
      if (m_first || chars != m_last) begin
        exp_q.push_back({32'(cap_edge + 1), any_err, chars});
        m_first = 1'b0;
        m_last  = chars;
      end
    end
  endtask

  // driver: one clock of bus value, with the model updated for that edge
  task automatic step(input logic [N-1:0] an, input logic [6:0] seg);
    int d = 0;
    @(negedge clk);
    an_n  = an;
    seg_n = seg;
    if (an == m_prev_an && seg == m_prev_seg) m_run++;
    else m_run = 1;
    m_prev_an  = an;
    m_prev_seg = seg;
    if (low_count(an) == 1 && m_run == SETTLE) begin
      for (int i = 0; i < N; i++) if (!an[i]) d = i;
      model_capture(d, seg, edge_cnt + 1);
    end
  endtask

  task automatic drive(input logic [N-1:0] an, input logic [6:0] seg, input int n);
    repeat (n) step(an, seg);
  endtask

  task automatic drive_digit(input int d, input logic [6:0] seg, input int n);
    logic [N-1:0] a = '1;
    a[d] = 1'b0;
    drive(a, seg, n);
  endtask

  task automatic scan4(input logic [6:0] g0, input logic [6:0] g1,
                       input logic [6:0] g2, input logic [6:0] g3, input int hold);
    drive_digit(0, g0, hold);
    drive_digit(1, g1, hold);
    drive_digit(2, g2, hold);
    drive_digit(3, g3, hold);
  endtask

  task automatic idle(input int n);
    drive('1, '1, n);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [EW-1:0] e;
    edge_cnt++;
    #1;
    if (!rst_n) begin
      mon_chars = '0;
      mon_err   = 1'b0;
      chk("rst_valid", 64'(frame_valid), 64'd0);
    end else if (frame_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(frame_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_edge", 64'(edge_cnt), 64'(e[EW-1 -: 32]));
        chk("frame_chars", 64'(frame_chars), 64'(e[CW-1:0]));
        chk("frame_err", 64'(frame_err), 64'(e[CW]));
        mon_chars = e[CW-1:0];
        mon_err   = e[CW];
      end
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e[EW-1 -: 32]) >= edge_cnt) break;
        chk("missing_valid", 64'(frame_valid), 64'd1);
        void'(exp_q.pop_front());
      end
    end
    chk("hold_chars", 64'(frame_chars), 64'(mon_chars));
    chk("hold_err", 64'(frame_err), 64'(mon_err));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog edges=%0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [N-1:0] a;
    logic [6:0]   s;
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(frame_valid), 64'd0);
    chk("reset_chars", 64'(frame_chars), 64'd0);
    chk("reset_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;

    scan4(G_H, G_A, G_P, G_Y, 8);
    idle(4);
    chk("hapy_chars", 64'(frame_chars), 64'h59504148);
    chk("hapy_err", 64'(frame_err), 64'd0);
    chk("hapy_pulses", 64'(pulse_cnt), 64'd1);

    p = pulse_cnt;
    repeat (3) scan4(G_H, G_A, G_P, G_Y, 8);
    idle(4);
    chk("rescan_pulses", 64'(pulse_cnt - p), 64'd0);
    scan4(G_H, G_A, G_SP, G_Y, 8);
    idle(4);
    chk("blank_chars", 64'(frame_chars), 64'h59204148);
    chk("blank_pulses", 64'(pulse_cnt - p), 64'd1);

    p = pulse_cnt;
    repeat (3) scan4(G_B, G_D, G_S, G_T, SETTLE - 1);
    idle(4);
    chk("short_hold_pulses", 64'(pulse_cnt - p), 64'd0);
    scan4(G_B, G_D, G_S, G_T, SETTLE);
    idle(4);
    chk("exact_hold_chars", 64'(frame_chars), 64'h54534442);
    chk("exact_hold_pulses", 64'(pulse_cnt - p), 64'd1);

    scan4(G_H, G_BAD, G_P, G_Y, 8);
    idle(4);
    chk("bad_chars", 64'(frame_chars), 64'h59503F48);
    chk("bad_err", 64'(frame_err), 64'd1);
    scan4(G_H, G_A, G_P, G_Y, 8);
    idle(4);
    chk("recover_err", 64'(frame_err), 64'd0);

    p = pulse_cnt;
    drive_digit(0, G_D, 8);
    drive_digit(1, G_O, 8);
    drive('1, G_S, 6);
    drive(4'b1100, G_S, 6);
    drive_digit(2, G_C, 8);
    drive_digit(3, G_T, 8);
    idle(4);
    chk("gap_chars", 64'(frame_chars), 64'h54434F44);
    chk("gap_pulses", 64'(pulse_cnt - p), 64'd1);

    drive_digit(0, G_T, 8);
    drive_digit(1, G_O, 8);
    @(negedge clk);
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    model_reset();
    @(negedge clk);
    chk("midrst_valid", 64'(frame_valid), 64'd0);
    chk("midrst_chars", 64'(frame_chars), 64'd0);
    chk("midrst_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    p = pulse_cnt;
    drive_digit(2, G_S, 8);
    drive_digit(3, G_C, 8);
    idle(3);
    chk("partial_after_rst", 64'(pulse_cnt - p), 64'd0);
    scan4(G_T, G_O, G_S, G_C, 8);
    idle(4);
    chk("tosc_chars", 64'(frame_chars), 64'h43534F54);
    chk("tosc_pulses", 64'(pulse_cnt - p), 64'd1);

    for (int n = 0; n < 300; n++) begin
      a = '1;
      case ($urandom_range(0, 9))
        0: a = '1;
        1: begin
          a[0] = 1'b0;
          a[$urandom_range(1, N - 1)] = 1'b0;
        end
        default: a[$urandom_range(0, N - 1)] = 1'b0;
      endcase
      if ($urandom_range(0, 7) == 0) s = 7'($urandom);
      else s = pat_tab[$urandom_range(0, 11)];
      drive(a, s, $urandom_range(1, 7));
    end
    idle(6);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
